// File: rtl/md_issue_ctrl.sv
// Issue controller between the execute stage and the multiply/divide unit.
// Define MD_TIMEOUT_EN to enable the LAUNCH/WAIT watchdog that drives md_err.
module md_issue_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_hiwrite,
  output logic        md_lowrite,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, SETTLE} state_t;

  state_t      state;
  logic        accept;
  logic        rd_sel;
  logic [31:0] rd_hold;
  logic        tmo;

  assign accept = req_valid && (state == IDLE) && !md_busy;
  assign stall  = req_valid && !accept;

  // Read data is taken from the unit in the strobe cycle so a write issued
  // one cycle earlier is already visible.
  assign rd_data = rd_valid ? (rd_sel ? md_lo : md_hi) : rd_hold;

`ifdef MD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tcnt;
  logic          err_q;

  // A WAIT cycle that sees Busy drop completes normally rather than timing out.
  assign tmo = ((state == LAUNCH) || ((state == WAIT) && md_busy)) &&
               (tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept && !req_op[2])
        tcnt <= '0;
      else if ((state == LAUNCH) || (state == WAIT))
        tcnt <= tcnt + 1'b1;
      if (tmo)
        err_q <= 1'b1;
    end
  end

  assign md_err = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT > 0);
  assign tmo    = 1'b0;
  assign md_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      md_start   <= 1'b0;
      md_hiwrite <= 1'b0;
      md_lowrite <= 1'b0;
      rd_valid   <= 1'b0;
      rd_sel     <= 1'b0;
      rd_hold    <= '0;
      md_a       <= '0;
      md_b       <= '0;
      md_op      <= '0;
    end else begin
      md_start   <= 1'b0;
      md_hiwrite <= 1'b0;
      md_lowrite <= 1'b0;
      rd_valid   <= 1'b0;
      if (rd_valid)
        rd_hold <= rd_data;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_op[2]) begin
              md_a     <= rs_val;
              md_b     <= rt_val;
              md_op    <= {1'b0, req_op[1:0]};
              md_start <= 1'b1;
              state    <= LAUNCH;
            end else if (!req_op[1]) begin
              rd_valid <= 1'b1;
              rd_sel   <= req_op[0];
            end else begin
              md_a       <= rs_val;
              md_hiwrite <= !req_op[0];
              md_lowrite <= req_op[0];
            end
          end
        end
        LAUNCH:  state <= tmo ? IDLE : WAIT;
        WAIT: begin
          if (!md_busy)
            state <= SETTLE;
          else if (tmo)
            state <= IDLE;
        end
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
